// File: rtl/parking_pkg.sv
// parking_pkg
// Shared constants and helpers for the campus car park control unit.
// Holds the lot size, the university quota, the hour-by-hour university
// reservation steps, the start-of-day hour, and the hour width. The vacancy
// helpers are used both for the display outputs and for admission decisions.
// Ports: none (package).
package parking_pkg;

    localparam int HOUR_W = 5;

    localparam logic [31:0] TOTAL   = 32'd700;
    localparam logic [31:0] UNI_MAX = 32'd500;

    localparam logic [31:0] RESERVE_MORNING = 32'd500;
    localparam logic [31:0] RESERVE_H13     = 32'd450;
    localparam logic [31:0] RESERVE_H14     = 32'd400;
    localparam logic [31:0] RESERVE_H15     = 32'd350;
    localparam logic [31:0] RESERVE_NIGHT   = 32'd200;

    localparam logic [HOUR_W-1:0] START_HOUR     = 5'd8;
    localparam logic [HOUR_W-1:0] LAST_HOUR      = 5'd23;
    localparam logic [HOUR_W-1:0] MORNING_HOUR   = 5'd8;
    localparam logic [HOUR_W-1:0] STEP13_HOUR    = 5'd13;
    localparam logic [HOUR_W-1:0] STEP14_HOUR    = 5'd14;
    localparam logic [HOUR_W-1:0] STEP15_HOUR    = 5'd15;
    localparam logic [HOUR_W-1:0] EVENING_HOUR   = 5'd16;

    typedef enum logic [2:0] {
        BAND_NIGHT,
        BAND_MORNING,
        BAND_H13,
        BAND_H14,
        BAND_H15
    } reserveBand_e;

    // Any hour outside 8..15 (including 24, which the hour counter's
    // successor of 23 can produce) falls into the night band.
    function automatic reserveBand_e bandForHour(input logic [HOUR_W-1:0] h);
        reserveBand_e band;
        band = BAND_NIGHT;
        if (h >= MORNING_HOUR && h < STEP13_HOUR) begin
            band = BAND_MORNING;
        end else if (h == STEP13_HOUR) begin
            band = BAND_H13;
        end else if (h == STEP14_HOUR) begin
            band = BAND_H14;
        end else if (h == STEP15_HOUR) begin
            band = BAND_H15;
        end
        return band;
    endfunction

    function automatic logic [31:0] reserveForHour(input logic [HOUR_W-1:0] h);
        logic [31:0] r;
        case (bandForHour(h))
            BAND_MORNING: r = RESERVE_MORNING;
            BAND_H13:     r = RESERVE_H13;
            BAND_H14:     r = RESERVE_H14;
            BAND_H15:     r = RESERVE_H15;
            default:      r = RESERVE_NIGHT;
        endcase
        return r;
    endfunction

    // University vacancy is bounded both by the university quota and by the
    // physical spaces left in the lot; both terms are clamped at zero.
    function automatic logic [31:0] uniVacancy(input logic [31:0] uniCount,
                                               input logic [31:0] genCount);
        logic [31:0] byQuota;
        logic [31:0] byLot;
        byQuota = (uniCount < UNI_MAX) ? (UNI_MAX - uniCount) : 32'd0;
        byLot   = ((uniCount + genCount) < TOTAL) ? (TOTAL - uniCount - genCount) : 32'd0;
        return (byQuota < byLot) ? byQuota : byLot;
    endfunction

    // General cars may use whatever the university does not hold: the larger
    // of the reservation and the university cars actually parked. When the
    // limit drops below the parked count the vacancy reads zero, never wraps.
    function automatic logic [31:0] genVacancy(input logic [31:0] uniCount,
                                               input logic [31:0] genCount,
                                               input logic [31:0] reserve);
        logic [31:0] held;
        logic [31:0] limit;
        held  = (reserve > uniCount) ? reserve : uniCount;
        limit = TOTAL - held;
        return (limit > genCount) ? (limit - genCount) : 32'd0;
    endfunction

endpackage

// File: rtl/parking_clock.sv
// parking_clock
// Time-of-day keeper for the car park: divides the system clock down to
// simulated hours and counts the hour of day, starting at 8 after reset.
// Build option PARKING_HOUR_WRAP_EN: when defined the hour wraps 23 -> 0;
// when undefined the hour stops at 23 and the cycle divider freezes.
// Ports:
//   clk        in   system clock
//   rst        in   synchronous active-high reset
//   hour       out  current hour of day
//   hour_tick  out  high in the cycle whose closing edge advances the hour
module parking_clock
    import parking_pkg::*;
#(
    parameter int HOUR_CYCLES = 1000
) (
    input  logic              clk,
    input  logic              rst,
    output logic [HOUR_W-1:0] hour,
    output logic              hour_tick
);

    localparam int CNT_W = (HOUR_CYCLES > 1) ? $clog2(HOUR_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST_CYCLE = CNT_W'(HOUR_CYCLES - 1);

    logic [CNT_W-1:0]  cycleCount_q;
    logic [CNT_W-1:0]  cycleCount_d;
    logic [HOUR_W-1:0] hour_q;
    logic [HOUR_W-1:0] hour_d;
    logic              frozen;

    // Without wrap-around the clock parks itself at the last hour of the day,
    // so both the divider and the hour stay put from then on.
`ifdef PARKING_HOUR_WRAP_EN
    assign frozen = 1'b0;
`else
    assign frozen = (hour_q == LAST_HOUR);
`endif

    // Divider and hour next-state: the hour moves on the same edge that
    // returns the divider to zero, and hour_tick flags that cycle.
    always_comb begin
        cycleCount_d = cycleCount_q;
        hour_d       = hour_q;
        hour_tick    = 1'b0;
        if (!frozen) begin
            if (cycleCount_q == LAST_CYCLE) begin
                cycleCount_d = '0;
                hour_tick    = 1'b1;
                hour_d       = (hour_q == LAST_HOUR) ? '0 : (hour_q + 1'b1);
            end else begin
                cycleCount_d = cycleCount_q + 1'b1;
            end
        end
    end

    // State register; reset restarts the day at the opening hour.
    always_ff @(posedge clk) begin
        if (rst) begin
            cycleCount_q <= '0;
            hour_q       <= START_HOUR;
        end else begin
            cycleCount_q <= cycleCount_d;
            hour_q       <= hour_d;
        end
    end

    assign hour = hour_q;

endmodule

// File: rtl/parking_cu.sv
// parking_cu
// Campus car park control unit. Counts university and general cars against
// the lot, applies exits before entries each cycle, and admits an entry only
// if the post-exit vacancy for its class is nonzero. The university
// reservation follows the hour of day supplied by parking_clock.
// Build option PARKING_HOUR_WRAP_EN (inside parking_clock): hour wraps 23 -> 0
// when defined, saturates at 23 otherwise; admission rules are identical.
// Ports:
//   clk, rst                 clock and synchronous active-high reset
//   car_entered              one-cycle entry request
//   is_uni_car_entered       entry is a university car
//   car_exited               one-cycle exit event
//   is_uni_car_exited        exit is a university car
//   uni_parked_car           university cars parked
//   parked_car               general cars parked
//   uni_vacated_space        spaces admissible to university cars
//   vacated_space            spaces admissible to general cars
//   hour                     current hour 0..23
//   uni_is_vacated_space     uni_vacated_space != 0
//   is_vacated_space         vacated_space != 0
module parking_cu
    import parking_pkg::*;
#(
    parameter int HOUR_CYCLES = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        car_entered,
    input  logic        is_uni_car_entered,
    input  logic        car_exited,
    input  logic        is_uni_car_exited,
    output logic [31:0] uni_parked_car,
    output logic [31:0] parked_car,
    output logic [31:0] uni_vacated_space,
    output logic [31:0] vacated_space,
    output logic [4:0]  hour,
    output logic        uni_is_vacated_space,
    output logic        is_vacated_space
);

    logic [31:0] uniCount_q;
    logic [31:0] uniCount_d;
    logic [31:0] genCount_q;
    logic [31:0] genCount_d;
    logic [31:0] reserve_q;
    logic [31:0] uniAfterExit;
    logic [31:0] genAfterExit;
    logic        hourTick;

    parking_clock #(
        .HOUR_CYCLES (HOUR_CYCLES)
    ) u_clock (
        .clk       (clk),
        .rst       (rst),
        .hour      (hour),
        .hour_tick (hourTick)
    );

    // Count next-state: exits first (ignored at zero), then the entry is
    // judged against the post-exit counts so an exit frees its space for an
    // entry arriving in the same cycle.
    always_comb begin
        uniAfterExit = uniCount_q;
        genAfterExit = genCount_q;
        if (car_exited) begin
            if (is_uni_car_exited) begin
                if (uniCount_q != 32'd0) begin
                    uniAfterExit = uniCount_q - 32'd1;
                end
            end else begin
                if (genCount_q != 32'd0) begin
                    genAfterExit = genCount_q - 32'd1;
                end
            end
        end

        uniCount_d = uniAfterExit;
        genCount_d = genAfterExit;
        if (car_entered) begin
            if (is_uni_car_entered) begin
                if (uniVacancy(uniAfterExit, genAfterExit) != 32'd0) begin
                    uniCount_d = uniAfterExit + 32'd1;
                end
            end else begin
                if (genVacancy(uniAfterExit, genAfterExit, reserve_q) != 32'd0) begin
                    genCount_d = genAfterExit + 32'd1;
                end
            end
        end
    end

    // Counters plus a registered copy of the reservation. The reservation is
    // loaded for the upcoming hour on hour_tick so it changes on the same
    // edge as the hour itself; the successor of 23 is 24, which maps to the
    // night band just as hour 0 does, so no wrap handling is needed here.
    always_ff @(posedge clk) begin
        if (rst) begin
            uniCount_q <= 32'd0;
            genCount_q <= 32'd0;
            reserve_q  <= reserveForHour(START_HOUR);
        end else begin
            uniCount_q <= uniCount_d;
            genCount_q <= genCount_d;
            if (hourTick) begin
                reserve_q <= reserveForHour(hour + 1'b1);
            end
        end
    end

    assign uni_parked_car       = uniCount_q;
    assign parked_car           = genCount_q;
    assign uni_vacated_space    = uniVacancy(uniCount_q, genCount_q);
    assign vacated_space        = genVacancy(uniCount_q, genCount_q, reserve_q);
    assign uni_is_vacated_space = (uni_vacated_space != 32'd0);
    assign is_vacated_space     = (vacated_space != 32'd0);

endmodule

// File: tb/tb_parking_cu.sv
// tb_parking_cu
// Self-checking bench for parking_cu. Every cycle is driven through one
// stimulus task that also advances a behavioural model of the car park and
// queues the expected outputs; each scenario task pops and compares them,
// and adds fixed-value checks at the interesting points of the scenario.
module tb_parking_cu;

    localparam int HC = 1000;

`ifdef PARKING_HOUR_WRAP_EN
    localparam bit WRAP = 1'b1;
`else
    localparam bit WRAP = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] u;
        logic [31:0] p;
        logic [31:0] uv;
        logic [31:0] v;
        logic [4:0]  h;
        logic        uf;
        logic        vf;
    } snap_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        car_entered;
    logic        is_uni_car_entered;
    logic        car_exited;
    logic        is_uni_car_exited;
    logic [31:0] uni_parked_car;
    logic [31:0] parked_car;
    logic [31:0] uni_vacated_space;
    logic [31:0] vacated_space;
    logic [4:0]  hour;
    logic        uni_is_vacated_space;
    logic        is_vacated_space;

    snap_t obs;
    snap_t exp;
    snap_t sbQ[$];

    int testsRun    = 0;
    int testsFailed = 0;

    int mU;
    int mP;
    int mHour;
    int mCnt;

    parking_cu #(
        .HOUR_CYCLES (HC)
    ) dut (
        .clk                  (clk),
        .rst                  (rst),
        .car_entered          (car_entered),
        .is_uni_car_entered   (is_uni_car_entered),
        .car_exited           (car_exited),
        .is_uni_car_exited    (is_uni_car_exited),
        .uni_parked_car       (uni_parked_car),
        .parked_car           (parked_car),
        .uni_vacated_space    (uni_vacated_space),
        .vacated_space        (vacated_space),
        .hour                 (hour),
        .uni_is_vacated_space (uni_is_vacated_space),
        .is_vacated_space     (is_vacated_space)
    );

    always #5 clk = ~clk;

    assign obs = {uni_parked_car, parked_car, uni_vacated_space, vacated_space,
                  hour, uni_is_vacated_space, is_vacated_space};

    function automatic int modelReserve(input int h);
        if (h >= 8 && h < 13) return 500;
        if (h == 13) return 450;
        if (h == 14) return 400;
        if (h == 15) return 350;
        return 200;
    endfunction

    function automatic int modelUniVac(input int u, input int p);
        int a;
        int b;
        a = 500 - u;
        b = 700 - u - p;
        return (a < b) ? a : b;
    endfunction

    function automatic int modelGenVac(input int u, input int p, input int h);
        int r;
        int gl;
        r  = modelReserve(h);
        gl = 700 - ((r > u) ? r : u);
        return (gl > p) ? (gl - p) : 0;
    endfunction

    function automatic snap_t modelSnap();
        snap_t s;
        s.u  = mU;
        s.p  = mP;
        s.uv = modelUniVac(mU, mP);
        s.v  = modelGenVac(mU, mP, mHour);
        s.h  = 5'(mHour);
        s.uf = (s.uv != 0);
        s.vf = (s.v != 0);
        return s;
    endfunction

    function automatic string fmtSnap(input snap_t s);
        return $sformatf("u=%0d p=%0d uv=%0d v=%0d h=%0d uf=%0b vf=%0b",
                         s.u, s.p, s.uv, s.v, s.h, s.uf, s.vf);
    endfunction

    function automatic int cyclesUntilHour(input int target);
        return (HC - mCnt) + (target - mHour - 1) * HC;
    endfunction

    // Drive one cycle of events, advance the model and queue its outputs.
    task automatic step(input logic ent, input logic entUni,
                        input logic ext, input logic extUni, input logic r);
        rst                = r;
        car_entered        = ent;
        is_uni_car_entered = entUni;
        car_exited         = ext;
        is_uni_car_exited  = extUni;
        if (r) begin
            mU = 0; mP = 0; mHour = 8; mCnt = 0;
        end else begin
            if (ext) begin
                if (extUni) begin
                    if (mU > 0) mU--;
                end else begin
                    if (mP > 0) mP--;
                end
            end
            if (ent) begin
                if (entUni) begin
                    if (modelUniVac(mU, mP) > 0) mU++;
                end else begin
                    if (modelGenVac(mU, mP, mHour) > 0) mP++;
                end
            end
            if (!(!WRAP && mHour == 23)) begin
                if (mCnt == HC - 1) begin
                    mCnt  = 0;
                    mHour = (mHour == 23) ? 0 : mHour + 1;
                end else begin
                    mCnt++;
                end
            end
        end
        sbQ.push_back(modelSnap());
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        exp = sbQ.pop_front(); testsRun++;
        if (obs !== exp) begin
            testsFailed++;
            $display("[TB] FAIL reset_model: got %s expected %s", fmtSnap(obs), fmtSnap(exp));
        end
        testsRun++;
        if (obs !== snap_t'({32'd0, 32'd0, 32'd500, 32'd200, 5'd8, 1'b1, 1'b1})) begin
            testsFailed++;
            $display("[TB] FAIL reset_values: got %s expected u=0 p=0 uv=500 v=200 h=8 uf=1 vf=1", fmtSnap(obs));
        end
    endtask

    task automatic test_entry();
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        exp = sbQ.pop_front(); testsRun++;
        if (obs !== exp) begin
            testsFailed++;
            $display("[TB] FAIL uni_entry: got %s expected %s", fmtSnap(obs), fmtSnap(exp));
        end
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        exp = sbQ.pop_front(); testsRun++;
        if (obs !== exp) begin
            testsFailed++;
            $display("[TB] FAIL gen_entry: got %s expected %s", fmtSnap(obs), fmtSnap(exp));
        end
        testsRun++;
        if (uni_parked_car !== 32'd1 || parked_car !== 32'd1 ||
            uni_vacated_space !== 32'd499 || vacated_space !== 32'd199) begin
            testsFailed++;
            $display("[TB] FAIL first_entries: got u=%0d p=%0d uv=%0d v=%0d expected u=1 p=1 uv=499 v=199",
                     uni_parked_car, parked_car, uni_vacated_space, vacated_space);
        end
    endtask

    task automatic test_back_to_back();
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        exp = sbQ.pop_front(); testsRun++;
        if (obs !== exp || parked_car !== 32'd1) begin
            testsFailed++;
            $display("[TB] FAIL exit_and_entry: got %s expected %s", fmtSnap(obs), fmtSnap(exp));
        end
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b0, 1'b1, (i < 2), 1'b0);
            exp = sbQ.pop_front(); testsRun++;
            if (obs !== exp) begin
                testsFailed++;
                $display("[TB] FAIL exit_sequence: got %s expected %s", fmtSnap(obs), fmtSnap(exp));
            end
        end
        testsRun++;
        if (uni_parked_car !== 32'd0 || parked_car !== 32'd0) begin
            testsFailed++;
            $display("[TB] FAIL exit_at_zero: got u=%0d p=%0d expected u=0 p=0", uni_parked_car, parked_car);
        end
    endtask

    task automatic test_general_full();
        for (int i = 0; i < 500; i++) begin
            step(1'b1, (i < 300), 1'b0, 1'b0, 1'b0);
            exp = sbQ.pop_front(); testsRun++;
            if (obs !== exp) begin
                testsFailed++;
                $display("[TB] FAIL fill_morning: got %s expected %s", fmtSnap(obs), fmtSnap(exp));
            end
        end
        repeat (cyclesUntilHour(9)) begin
            step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            exp = sbQ.pop_front(); testsRun++;
            if (obs !== exp) begin
                testsFailed++;
                $display("[TB] FAIL idle_to_9: got %s expected %s", fmtSnap(obs), fmtSnap(exp));
            end
        end
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        exp = sbQ.pop_front(); testsRun++;
        if (obs !== exp) begin
            testsFailed++;
            $display("[TB] FAIL gen_over_limit: got %s expected %s", fmtSnap(obs), fmtSnap(exp));
        end
        testsRun++;
        if (hour !== 5'd9 || uni_parked_car !== 32'd300 || parked_car !== 32'd200 ||
            vacated_space !== 32'd0 || is_vacated_space !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL general_refused: got h=%0d u=%0d p=%0d v=%0d vf=%0b expected h=9 u=300 p=200 v=0 vf=0",
                     hour, uni_parked_car, parked_car, vacated_space, is_vacated_space);
        end
    endtask

    task automatic test_afternoon();
        repeat (cyclesUntilHour(13)) begin
            step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            exp = sbQ.pop_front(); testsRun++;
            if (obs !== exp) begin
                testsFailed++;
                $display("[TB] FAIL idle_to_13: got %s expected %s", fmtSnap(obs), fmtSnap(exp));
            end
        end
        testsRun++;
        if (hour !== 5'd13 || vacated_space !== 32'd50) begin
            testsFailed++;
            $display("[TB] FAIL hour13_vacancy: got h=%0d v=%0d expected h=13 v=50", hour, vacated_space);
        end
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        exp = sbQ.pop_front(); testsRun++;
        if (obs !== exp || parked_car !== 32'd201) begin
            testsFailed++;
            $display("[TB] FAIL hour13_entry: got %s expected %s", fmtSnap(obs), fmtSnap(exp));
        end
    endtask

    task automatic test_evening();
        repeat (cyclesUntilHour(16)) begin
            step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            exp = sbQ.pop_front(); testsRun++;
            if (obs !== exp) begin
                testsFailed++;
                $display("[TB] FAIL idle_to_16: got %s expected %s", fmtSnap(obs), fmtSnap(exp));
            end
        end
        testsRun++;
        if (hour !== 5'd16 || vacated_space !== 32'd199) begin
            testsFailed++;
            $display("[TB] FAIL hour16_vacancy: got h=%0d v=%0d expected h=16 v=199", hour, vacated_space);
        end
        for (int i = 0; i < 200; i++) begin
            step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            exp = sbQ.pop_front(); testsRun++;
            if (obs !== exp) begin
                testsFailed++;
                $display("[TB] FAIL evening_fill: got %s expected %s", fmtSnap(obs), fmtSnap(exp));
            end
        end
        testsRun++;
        if (parked_car !== 32'd400 || is_vacated_space !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL evening_full: got p=%0d vf=%0b expected p=400 vf=0", parked_car, is_vacated_space);
        end
        for (int i = 0; i < 300; i++) begin
            step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
            exp = sbQ.pop_front(); testsRun++;
            if (obs !== exp) begin
                testsFailed++;
                $display("[TB] FAIL evening_exits: got %s expected %s", fmtSnap(obs), fmtSnap(exp));
            end
        end
        testsRun++;
        if (parked_car !== 32'd100) begin
            testsFailed++;
            $display("[TB] FAIL after_exits: got p=%0d expected p=100", parked_car);
        end
    endtask

    task automatic test_uni_full();
        for (int i = 0; i < 201; i++) begin
            step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
            exp = sbQ.pop_front(); testsRun++;
            if (obs !== exp) begin
                testsFailed++;
                $display("[TB] FAIL uni_fill: got %s expected %s", fmtSnap(obs), fmtSnap(exp));
            end
        end
        testsRun++;
        if (uni_parked_car !== 32'd500 || uni_vacated_space !== 32'd0 || uni_is_vacated_space !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL uni_quota: got u=%0d uv=%0d uf=%0b expected u=500 uv=0 uf=0",
                     uni_parked_car, uni_vacated_space, uni_is_vacated_space);
        end
    endtask

    task automatic test_mid_reset();
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        exp = sbQ.pop_front(); testsRun++;
        if (obs !== exp) begin
            testsFailed++;
            $display("[TB] FAIL mid_reset_model: got %s expected %s", fmtSnap(obs), fmtSnap(exp));
        end
        testsRun++;
        if (uni_parked_car !== 32'd0 || parked_car !== 32'd0 || hour !== 5'd8) begin
            testsFailed++;
            $display("[TB] FAIL mid_reset: got u=%0d p=%0d h=%0d expected u=0 p=0 h=8",
                     uni_parked_car, parked_car, hour);
        end
    endtask

    task automatic test_hour_limit();
        repeat (16 * HC) begin
            step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            exp = sbQ.pop_front(); testsRun++;
            if (obs !== exp) begin
                testsFailed++;
                $display("[TB] FAIL day_run: got %s expected %s", fmtSnap(obs), fmtSnap(exp));
            end
        end
        testsRun++;
        if (hour !== (WRAP ? 5'd0 : 5'd23) || vacated_space !== 32'd500) begin
            testsFailed++;
            $display("[TB] FAIL hour_end_of_day: got h=%0d v=%0d expected h=%0d v=500",
                     hour, vacated_space, (WRAP ? 0 : 23));
        end
    endtask

    initial begin
        rst                = 1'b1;
        car_entered        = 1'b0;
        is_uni_car_entered = 1'b0;
        car_exited         = 1'b0;
        is_uni_car_exited  = 1'b0;
        mU = 0; mP = 0; mHour = 8; mCnt = 0;

        test_reset();
        test_entry();
        test_back_to_back();
        test_general_full();
        test_afternoon();
        test_evening();
        test_uni_full();
        test_mid_reset();
        test_hour_limit();

        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        exp = sbQ.pop_front(); testsRun++;
        if (obs !== exp) begin
            testsFailed++;
            $display("[TB] FAIL final_idle: got %s expected %s", fmtSnap(obs), fmtSnap(exp));
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
